// File: rtl/fsu_add_sched.sv
// fsu_add_sched: shares one FSU unary adder among NREQ requesters in bursts.
// Each burst grants one requester, pulses the adder's accumulator clear,
// streams the winner's bits for L cycles, waits LAT cycles for the adder
// pipeline to empty, then offers the count of adder 1s on a valid/ready port.
//
// Result handshake: res_valid_o rises on entry to REPORT and holds res_id_o
// and res_cnt_o stable until the cycle where res_valid_o && res_ready_i is seen
// at a rising clk edge. That edge completes the transfer. res_valid_o never
// drops without acceptance.
//
// Build option: define FSU_SCHED_FIXPRI_EN for fixed priority (lowest set req
// index wins, pointer held at 0). Otherwise arbitration is round-robin.
// dbg_state_o exposes the FSM state for observation.
module fsu_add_sched #(
    parameter int NREQ = 4,
    parameter int IDIM = 3,
    parameter int LWID = 8,
    parameter int LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*IDIM-1:0]    req_bit_i,
    input  logic [LWID-1:0]         cfg_len_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    add_clr_o,
    output logic [IDIM-1:0]         add_bit_o,
    input  logic                    add_obit_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [$clog2(NREQ)-1:0] res_id_o,
    output logic [LWID:0]           res_cnt_o,
    output logic [2:0]              dbg_state_o
);

    localparam int IW  = $clog2(NREQ);
    localparam int IW1 = IW + 1;
    localparam int CW  = LWID + 1;
    localparam int DW  = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {LWID{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;   // granted requester for the current burst
    logic [IW-1:0]   ptr_q, ptr_d;   // round-robin search start
    logic [CW-1:0]   len_q, len_d;   // STREAM cycles remaining
    logic [DW-1:0]   drn_q, drn_d;   // DRAIN cycles remaining
    logic [CW-1:0]   cnt_q, cnt_d;   // adder 1s seen in the burst window
    logic [LAT-1:0]  act_q, act_d;   // STREAM-active history; tap LAT-1 aligns with add_obit_i
    logic [IW-1:0]   pick;           // arbitration winner among current requests

`ifdef FSU_SCHED_FIXPRI_EN
    // Fixed priority: lowest-indexed active request wins.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) pick = IW'(i);
        end
    end
`else
    logic            rr_found;
    logic [IW1-1:0]  rr_sum;
    logic [IW-1:0]   rr_idx;

    // Round-robin: first active request at or after the pointer, wrapping.
    always_comb begin
        pick     = '0;
        rr_found = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_sum = {1'b0, ptr_q} + IW1'(i);
            if (rr_sum >= IW1'(NREQ)) rr_sum = rr_sum - IW1'(NREQ);
            rr_idx = rr_sum[IW-1:0];
            if (!rr_found && req_i[rr_idx]) begin
                pick     = rr_idx;
                rr_found = 1'b1;
            end
        end
    end
`endif

    // Next-state logic for the burst sequencer, count window and counter.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        drn_d   = drn_q;
        cnt_d   = cnt_q;
        act_d   = '0;

        act_d[0] = (state_q == S_STREAM);
        for (int i = 1; i < LAT; i++) begin
            act_d[i] = act_q[i-1];
        end

        // Only adder output belonging to this burst's L input cycles is counted.
        if (act_q[LAT-1] && add_obit_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    win_d   = pick;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                len_d   = (cfg_len_i == '0) ? CNT_MAX : {1'b0, cfg_len_i};
                cnt_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                len_d = len_q - CW'(1);
                if (len_q == CW'(1)) begin
                    drn_d   = DW'(LAT);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q - DW'(1);
                if (drn_q == DW'(1)) state_d = S_REPORT;
            end
            S_REPORT: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
`ifdef FSU_SCHED_FIXPRI_EN
                    ptr_d = '0;
`else
                    ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            len_q   <= '0;
            drn_q   <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            drn_q   <= drn_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    // Grant and adder input mux, live only while streaming.
    always_comb begin
        gnt_o     = '0;
        add_bit_o = '0;
        if (state_q == S_STREAM) begin
            gnt_o[win_q] = 1'b1;
            add_bit_o    = req_bit_i[win_q*IDIM +: IDIM];
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign add_clr_o   = (state_q == S_CLEAR);
    assign res_valid_o = (state_q == S_REPORT);
    assign res_id_o    = win_q;
    assign res_cnt_o   = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fsu_add_sched.sv
// tb_fsu_add_sched: bench for fsu_add_sched with an ideal LAT-cycle adder.
module tb_fsu_add_sched;

  localparam int NREQ = 4;
  localparam int IDIM = 3;
  localparam int LWID = 8;
  localparam int LAT  = 2;
  localparam int IW   = $clog2(NREQ);
  localparam int BW   = NREQ * IDIM;

`ifdef FSU_SCHED_FIXPRI_EN
  localparam bit FIXPRI = 1'b1;
`else
  localparam bit FIXPRI = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_i = '0;
  logic [BW-1:0]   req_bit_i = '0;
  logic [LWID-1:0] cfg_len_i = '0;
  logic [NREQ-1:0] gnt_o;
  logic            busy_o;
  logic            add_clr_o;
  logic [IDIM-1:0] add_bit_o;
  logic            add_obit_i;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic [IW-1:0]   res_id_o;
  logic [LWID:0]   res_cnt_o;
  logic [2:0]      dbg_state_o;

  always #5 clk = ~clk;

  fsu_add_sched #(.NREQ(NREQ), .IDIM(IDIM), .LWID(LWID), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .req_bit_i  (req_bit_i),
    .cfg_len_i  (cfg_len_i),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o),
    .add_clr_o  (add_clr_o),
    .add_bit_o  (add_bit_o),
    .add_obit_i (add_obit_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_id_o   (res_id_o),
    .res_cnt_o  (res_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // Ideal adder: add_obit is add_bit[0] delayed LAT cycles, zero after reset.
  logic [LAT-1:0] adder_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) adder_pipe <= '0;
    else        adder_pipe <= {adder_pipe[LAT-2:0], add_bit_o[0]};
  end
  assign add_obit_i = adder_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int model_ptr = 0;
  logic [LWID:0] exp_q[$];

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // Arbitration rule from the requester's point of view.
  function automatic int model_winner(input logic [NREQ-1:0] r);
    if (FIXPRI) begin
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
    end else begin
      for (int i = 0; i < NREQ; i++) if (r[(model_ptr + i) % NREQ]) return (model_ptr + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [BW-1:0] make_bits(input int mode, input int k);
    logic [BW-1:0] v;
    case (mode)
      0:       v = '1;
      1:       v = (k % 2 == 0) ? '1 : '0;
      default: v = BW'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called from an IDLE cycle, 1 time unit after a rising edge.
  task automatic do_burst(input logic [NREQ-1:0] r, input logic [LWID-1:0] len, input int mode,
                          input int delay, input bit drop, output int got_id, output int got_cnt);
    int win;
    int len_cycles;
    int ones;
    logic [BW-1:0] v;
    win = model_winner(r);
    len_cycles = (len == 0) ? (1 << LWID) : int'(len);
    ones = 0;
    req_i = r;
    cfg_len_i = len;
    res_ready_i = 1'b0;
    @(posedge clk); #1;
    check("clr_pulse", add_clr_o, 1);
    check("busy_clr", busy_o, 1);
    check("gnt_in_clr", gnt_o, 0);
    for (int k = 0; k < len_cycles; k++) begin
      @(posedge clk); #1;
      v = make_bits(mode, k);
      req_bit_i = v;
      if (k == 0) cfg_len_i = LWID'($urandom);
      #1;
      check("gnt_stream", gnt_o, 1 << win);
      check("add_bit_mux", add_bit_o, IDIM'(v >> (win * IDIM)));
      if (k == 0) check("clr_one_cycle", add_clr_o, 0);
      ones += int'(v[win * IDIM]);
      if (drop && k == 1) req_i = '0;
    end
    exp_q.push_back((LWID + 1)'(ones > (1 << LWID) ? (1 << LWID) : ones));
    for (int d = 0; d < LAT; d++) begin
      @(posedge clk); #1;
      req_bit_i = BW'($urandom);
      #1;
      check("gnt_drain", gnt_o, 0);
      check("add_bit_drain", add_bit_o, 0);
      check("valid_early", res_valid_o, 0);
    end
    if (delay == 0) res_ready_i = 1'b1;
    @(posedge clk); #1;
    check("res_valid", res_valid_o, 1);
    check("res_id", res_id_o, win);
    check("res_cnt", res_cnt_o, exp_q[0]);
    got_id = int'(res_id_o);
    got_cnt = int'(res_cnt_o);
    for (int d = 0; d < delay; d++) begin
      @(posedge clk); #1;
      check("hold_valid", res_valid_o, 1);
      check("hold_id", res_id_o, win);
      check("hold_cnt", res_cnt_o, exp_q[0]);
      check("hold_no_clr", add_clr_o, 0);
    end
    res_ready_i = 1'b1;
    @(posedge clk); #1;
    res_ready_i = 1'b0;
    check("idle_after_accept", busy_o, 0);
    check("valid_dropped", res_valid_o, 0);
    void'(exp_q.pop_front());
    model_ptr = FIXPRI ? 0 : (win + 1) % NREQ;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [LWID-1:0] len;
    int              mode;
    int              delay;
    bit              drop;
    int              exp_id;
    int              exp_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int gid, gcnt;
    logic [NREQ-1:0] rr;

    // Round-robin sweep with all four requesting.
    for (int i = 0; i < 5; i++) tbl[i] = '{4'b1111, 8'd4, 0, 0, 1'b0, FIXPRI ? 0 : (i % NREQ), 4};
    tbl[5]  = '{4'b0001, 8'd8, 0, 0,  1'b0, 0, 8};
    tbl[6]  = '{4'b0001, 8'd0, 0, 0,  1'b0, 0, 256};
    tbl[7]  = '{4'b0010, 8'd3, 1, 10, 1'b0, 1, 2};
    tbl[8]  = '{4'b0100, 8'd6, 1, 0,  1'b1, 2, 3};
    tbl[9]  = '{4'b1111, 8'd2, 0, 0,  1'b0, FIXPRI ? 0 : 3, 2};
    tbl[10] = '{4'b1010, 8'd5, 1, 0,  1'b0, 1, 3};

    // Reset values while rst_n is held low.
    #12;
    check("rst_gnt", gnt_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_clr", add_clr_o, 0);
    check("rst_add_bit", add_bit_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_id", res_id_o, 0);
    check("rst_cnt", res_cnt_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort a burst mid-STREAM with an asynchronous reset pulse.
    req_i = 4'b0100;
    cfg_len_i = 8'd10;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_bit_i = '1;
    end
    #1;
    check("pre_abort_gnt", gnt_o, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("abort_gnt", gnt_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_valid", res_valid_o, 0);
    check("abort_add_bit", add_bit_o, 0);
    check("abort_cnt", res_cnt_o, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    req_i = '0;
    model_ptr = 0;

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      do_burst(tbl[i].req, tbl[i].len, tbl[i].mode, tbl[i].delay, tbl[i].drop, gid, gcnt);
      check("tbl_id", gid, tbl[i].exp_id);
      check("tbl_cnt", gcnt, tbl[i].exp_cnt);
    end

    // Randomized bursts against the model, with idle gaps.
    for (int n = 0; n < 25; n++) begin
      rr = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_burst(rr, LWID'($urandom_range(1, 12)), 2, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), gid, gcnt);
      if ($urandom_range(0, 2) == 0) begin
        req_i = '0;
        for (int g = 0; g < 3; g++) begin
          @(posedge clk); #1;
          check("idle_busy", busy_o, 0);
          check("idle_clr", add_clr_o, 0);
        end
      end
    end

    req_i = '0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
